// File: rtl/xt_hb_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Package : XT_BUS                                                           |
// | XT_HB master-side types and the arbiter state encoding.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package XT_BUS;

   localparam int HB_ADDR_WIDTH = 32;
   localparam int HB_DATA_WIDTH = 32;

   typedef struct packed {
      logic                     read;
      logic                     write;
      logic [HB_ADDR_WIDTH-1:0] raddr;
      logic [HB_ADDR_WIDTH-1:0] waddr;
      logic [HB_DATA_WIDTH-1:0] wdata;
      logic [1:0]               write_width;
   } hb_master_in_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/xt_hb_arbiter_rr_picker.sv
// +----------------------------------------------------------------------------+
// | Module  : rr_picker                                                        |
// | Combinational round-robin encoder: first requester after last_id wins.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_picker #(
   parameter int N = 2,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last_id,
   output logic [W-1:0] winner,
   output logic         found
);

   logic [W-1:0] cand;

   // Scan last_id+1 .. last_id+N so last_id itself has the lowest priority.
   always_comb begin
      cand   = '0;
      winner = '0;
      found  = 1'b0;
      for (int k = 1; k <= N; k++) begin
         cand = W'((int'(last_id) + k) % N);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/xt_hb_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module  : xt_hb_arbiter                                                    |
// | Round-robin multi-master arbiter with per-master lock for XT_HB.          |
// | Optional lock watchdog: define XT_HB_ARB_LOCK_TIMEOUT_EN.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module xt_hb_arbiter
   import XT_BUS::*;
#(
   parameter int MASTER_NUM   = 2,
   parameter int LOCK_TIMEOUT = 64,
   localparam int ID_W = $clog2(MASTER_NUM)
) (
   input  logic                  hb_clk,
   input  logic                  rst_sync,
   input  logic [MASTER_NUM-1:0] master_req,
   input  logic [MASTER_NUM-1:0] master_lock,
   input  hb_master_in_t         master_in [MASTER_NUM],
   output logic [MASTER_NUM-1:0] master_accept,
   output logic [MASTER_NUM-1:0] master_stall,
   output logic [31:0]           master_rdata,
   output logic [MASTER_NUM-1:0] master_rvalid,
   output logic                  bus_req,
   output hb_master_in_t         bus_in,
   input  logic                  bus_accept,
   input  logic                  bus_stall,
   input  logic [31:0]           bus_rdata,
   output logic                  grant_valid,
   output logic [ID_W-1:0]       grant_id,
   output logic                  lock_timeout
);

   arb_state_t            state_q, state_d;
   logic [ID_W-1:0]       grant_id_q, grant_id_d;
   logic [ID_W-1:0]       last_id_q, last_id_d;
   logic [ID_W-1:0]       rd_id_q, rd_id_d;
   logic                  rd_pend_q, rd_pend_d;

   logic [MASTER_NUM-1:0] gnt_oh;
   logic [MASTER_NUM-1:0] lock_block;
   logic                  owner_req;
   logic                  owner_lock;
   logic                  done;
   logic                  handover;
   logic                  timeout_fire;
   logic [ID_W-1:0]       pick_last;
   logic [ID_W-1:0]       pick_id;
   logic                  pick_found;

   assign gnt_oh     = {{(MASTER_NUM-1){1'b0}}, 1'b1} << grant_id_q;
   assign owner_req  = master_req[grant_id_q];
   assign owner_lock = master_lock[grant_id_q] & ~lock_block[grant_id_q];
   assign done       = (state_q == BUSY) & owner_req & bus_accept & ~bus_stall;
   // From IDLE rotate after the last released owner; on handover rotate after the current one.
   assign pick_last  = (state_q == IDLE) ? last_id_q : grant_id_q;

   rr_picker #(.N(MASTER_NUM)) u_picker (
      .req     (master_req),
      .last_id (pick_last),
      .winner  (pick_id),
      .found   (pick_found)
   );

   always_ff @(posedge hb_clk) begin
      if (rst_sync) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         last_id_q  <= ID_W'(MASTER_NUM - 1);
         rd_pend_q  <= 1'b0;
         rd_id_q    <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         last_id_q  <= last_id_d;
         rd_pend_q  <= rd_pend_d;
         rd_id_q    <= rd_id_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      last_id_d  = last_id_q;
      handover   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d    = BUSY;
               grant_id_d = pick_id;
            end
         end
         BUSY: begin
            if (done) begin
               if (owner_lock) state_d  = LOCKED;
               else            handover = 1'b1;
            end
         end
         LOCKED: begin
            if (timeout_fire || !owner_lock) handover = 1'b1;
            else if (owner_req)               state_d  = BUSY;
         end
         default: state_d = IDLE;
      endcase
      // Re-arbitrate in the handover cycle so the next owner starts without a bubble.
      if (handover) begin
         last_id_d = grant_id_q;
         if (pick_found) begin
            state_d    = BUSY;
            grant_id_d = pick_id;
         end else begin
            state_d    = IDLE;
         end
      end
      rd_pend_d = done & bus_in.read;
      rd_id_d   = grant_id_q;
   end

   always_comb begin
      bus_req      = (state_q == BUSY) & owner_req;
      bus_in       = master_in[grant_id_q];
      grant_valid  = (state_q != IDLE);
      grant_id     = grant_id_q;
      master_rdata = bus_rdata;
      for (int i = 0; i < MASTER_NUM; i++) begin
         master_accept[i] = (state_q == BUSY) & gnt_oh[i] & bus_accept;
         master_stall[i]  = master_req[i] & (~((state_q == BUSY) & gnt_oh[i]) | bus_stall);
         master_rvalid[i] = rd_pend_q & (rd_id_q == ID_W'(i));
      end
   end

`ifdef XT_HB_ARB_LOCK_TIMEOUT_EN
   localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

   logic [CNT_W-1:0]      wd_cnt_q, wd_cnt_d;
   logic [MASTER_NUM-1:0] lock_block_q, lock_block_d;
   logic                  lock_timeout_q;
   logic                  others_req;

   assign others_req   = |(master_req & ~gnt_oh);
   assign timeout_fire = (state_q == LOCKED) & others_req &
                         (wd_cnt_q == CNT_W'(LOCK_TIMEOUT - 1));

   always_comb begin
      wd_cnt_d = '0;
      if ((state_q == LOCKED) && (state_d == LOCKED))
         wd_cnt_d = others_req ? wd_cnt_q + CNT_W'(1) : wd_cnt_q;
      // A block outlives the forced release until the master lets go of its lock.
      lock_block_d = (lock_block_q & master_lock) | (timeout_fire ? gnt_oh : '0);
   end

   always_ff @(posedge hb_clk) begin
      if (rst_sync) begin
         wd_cnt_q       <= '0;
         lock_block_q   <= '0;
         lock_timeout_q <= 1'b0;
      end else begin
         wd_cnt_q       <= wd_cnt_d;
         lock_block_q   <= lock_block_d;
         lock_timeout_q <= timeout_fire;
      end
   end

   assign lock_block   = lock_block_q;
   assign lock_timeout = lock_timeout_q;
`else
   logic unused_cfg;

   assign unused_cfg   = (LOCK_TIMEOUT != 0);
   assign timeout_fire = 1'b0;
   assign lock_block   = '0;
   assign lock_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xt_hb_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_xt_hb_arbiter                                                 |
// | Self-checking bench for xt_hb_arbiter with a read-data scoreboard.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_xt_hb_arbiter;
   import XT_BUS::*;

`ifdef XT_HB_ARB_LOCK_TIMEOUT_EN
   localparam int TB_LT = 8;
`else
   localparam int TB_LT = 64;
`endif

   logic          hb_clk;
   logic          rst_sync;
   logic [1:0]    master_req;
   logic [1:0]    master_lock;
   hb_master_in_t master_in [2];
   logic [1:0]    master_accept;
   logic [1:0]    master_stall;
   logic [31:0]   master_rdata;
   logic [1:0]    master_rvalid;
   logic          bus_req;
   hb_master_in_t bus_in;
   logic          bus_accept;
   logic          bus_stall;
   logic [31:0]   bus_rdata;
   logic          grant_valid;
   logic [0:0]    grant_id;
   logic          lock_timeout;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
   } sb_t;

   sb_t sb [$];
   sb_t sb_e;
   int  n_tests = 0;
   int  n_fail  = 0;
   bit  mon_en  = 1'b0;

   xt_hb_arbiter #(.MASTER_NUM(2), .LOCK_TIMEOUT(TB_LT)) dut (
      .hb_clk        (hb_clk),
      .rst_sync      (rst_sync),
      .master_req    (master_req),
      .master_lock   (master_lock),
      .master_in     (master_in),
      .master_accept (master_accept),
      .master_stall  (master_stall),
      .master_rdata  (master_rdata),
      .master_rvalid (master_rvalid),
      .bus_req       (bus_req),
      .bus_in        (bus_in),
      .bus_accept    (bus_accept),
      .bus_stall     (bus_stall),
      .bus_rdata     (bus_rdata),
      .grant_valid   (grant_valid),
      .grant_id      (grant_id),
      .lock_timeout  (lock_timeout)
   );

   initial hb_clk = 1'b0;
   always #5 hb_clk = ~hb_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge hb_clk);
      #1;
   endtask

   task automatic settle();
      @(negedge hb_clk);
   endtask

   task automatic do_reset();
      next_cycle();
      rst_sync    = 1'b1;
      master_req  = 2'b00;
      master_lock = 2'b00;
      bus_accept  = 1'b0;
      bus_stall   = 1'b0;
      next_cycle();
      rst_sync    = 1'b0;
   endtask

   // Read-data scoreboard: every rvalid must match the oldest pushed read.
   always @(negedge hb_clk) begin
      if (mon_en && (master_rvalid !== 2'b00)) begin
         if (sb.size() == 0) begin
            chk("rv_unexpected", 32'(master_rvalid), 32'd0);
         end else begin
            sb_e = sb.pop_front();
            chk("rv_owner", 32'(master_rvalid), 32'd1 << sb_e.id);
            chk("rv_rdata", master_rdata, sb_e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst_sync    = 1'b1;
      master_req  = 2'b11;
      master_lock = 2'b00;
      bus_accept  = 1'b0;
      bus_stall   = 1'b0;
      bus_rdata   = '0;
      for (int i = 0; i < 2; i++) begin
         master_in[i]       = '0;
         master_in[i].write = 1'b1;
         master_in[i].waddr = 32'h100 * (i + 1);
      end

      // Reset state
      next_cycle();
      settle();
      chk("rst_stall", 32'(master_stall), 32'd3);
      chk("rst_breq", 32'(bus_req), 32'd0);
      chk("rst_gvalid", 32'(grant_valid), 32'd0);
      chk("rst_accept", 32'(master_accept), 32'd0);
      chk("rst_rvalid", 32'(master_rvalid), 32'd0);
      chk("rst_lockto", 32'(lock_timeout), 32'd0);
      mon_en = 1'b1;

      // Continuous requests alternate with no idle cycle
      next_cycle();
      rst_sync   = 1'b0;
      bus_accept = 1'b1;
      settle();
      chk("idle_stall", 32'(master_stall), 32'd3);
      chk("idle_breq", 32'(bus_req), 32'd0);
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         settle();
         chk("alt_gid", 32'(grant_id), 32'(k % 2));
         chk("alt_breq", 32'(bus_req), 32'd1);
         chk("alt_accept", 32'(master_accept), 32'd1 << (k % 2));
         chk("alt_stall", 32'(master_stall), 32'd1 << (1 - (k % 2)));
         chk("alt_waddr", bus_in.waddr, 32'h100 * ((k % 2) + 1));
      end

      // Stalled read from master 0 while master 1 waits
      do_reset();
      master_req         = 2'b11;
      master_in[0].read  = 1'b1;
      master_in[0].write = 1'b0;
      bus_stall          = 1'b1;
      bus_accept         = 1'b1;
      settle();
      chk("rd_idle_stall", 32'(master_stall), 32'd3);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         settle();
         chk("rd_wait_stall", 32'(master_stall), 32'd3);
         chk("rd_wait_breq", 32'(bus_req), 32'd1);
         chk("rd_wait_gid", 32'(grant_id), 32'd0);
      end
      next_cycle();
      bus_stall = 1'b0;
      bus_rdata = 32'hCAFE_0001;
      sb.push_back('{id: 4'd0, data: 32'hCAFE_0001});
      settle();
      chk("rd_done_stall", 32'(master_stall), 32'd2);
      chk("rd_done_accept", 32'(master_accept), 32'd1);
      next_cycle();
      master_req         = 2'b10;
      master_in[0].read  = 1'b0;
      master_in[0].write = 1'b1;
      bus_stall          = 1'b1;
      settle();
      chk("rd_next_gid", 32'(grant_id), 32'd1);
      next_cycle();
      settle();
      chk("rd_rvalid_pulse", 32'(master_rvalid), 32'd0);

      // Master 1 locks the bus for four writes while master 0 waits
      do_reset();
      master_req  = 2'b10;
      master_lock = 2'b10;
      bus_accept  = 1'b1;
      bus_stall   = 1'b0;
      settle();
      chk("lk_idle_gvalid", 32'(grant_valid), 32'd0);
      for (int w = 0; w < 4; w++) begin
         next_cycle();
         if (w == 0) master_req = 2'b11;
         settle();
         chk("lk_gid", 32'(grant_id), 32'd1);
         chk("lk_accept", 32'(master_accept), 32'd2);
         chk("lk_stall", 32'(master_stall), 32'd1);
         next_cycle();
         if (w == 3) begin
            master_lock = 2'b00;
            master_req  = 2'b01;
         end
         settle();
         chk("lk_hold_gid", 32'(grant_id), 32'd1);
         chk("lk_hold_breq", 32'(bus_req), 32'd0);
         chk("lk_hold_accept", 32'(master_accept), 32'd0);
         chk("lk_no_timeout", 32'(lock_timeout), 32'd0);
      end
      next_cycle();
      settle();
      chk("lk_rel_gid", 32'(grant_id), 32'd0);
      chk("lk_rel_breq", 32'(bus_req), 32'd1);
      chk("lk_rel_accept", 32'(master_accept), 32'd1);
      chk("lk_rel_stall", 32'(master_stall), 32'd0);

      // Reset while a read is stalled on the bus
      next_cycle();
      rst_sync           = 1'b1;
      bus_stall          = 1'b1;
      master_in[0].read  = 1'b1;
      master_in[0].write = 1'b0;
      settle();
      chk("rstm_breq", 32'(bus_req), 32'd1);
      next_cycle();
      rst_sync = 1'b0;
      settle();
      chk("rstm_gvalid", 32'(grant_valid), 32'd0);
      chk("rstm_breq_after", 32'(bus_req), 32'd0);
      chk("rstm_gid", 32'(grant_id), 32'd0);
      next_cycle();
      settle();
      chk("rstm_rvalid", 32'(master_rvalid), 32'd0);
      master_in[0].read  = 1'b0;
      master_in[0].write = 1'b1;

`ifdef XT_HB_ARB_LOCK_TIMEOUT_EN
      // Idle lock owner is forced off after LOCK_TIMEOUT waiting cycles
      do_reset();
      master_req  = 2'b10;
      master_lock = 2'b10;
      bus_accept  = 1'b1;
      bus_stall   = 1'b0;
      settle();
      next_cycle();
      settle();
      chk("to_first_gid", 32'(grant_id), 32'd1);
      next_cycle();
      master_req = 2'b01;
      for (int i = 0; i < TB_LT; i++) begin
         if (i > 0) next_cycle();
         settle();
         chk("to_hold_gid", 32'(grant_id), 32'd1);
         chk("to_hold_pulse", 32'(lock_timeout), 32'd0);
      end
      next_cycle();
      master_req = 2'b11;
      settle();
      chk("to_pulse", 32'(lock_timeout), 32'd1);
      chk("to_new_gid", 32'(grant_id), 32'd0);
      chk("to_new_accept", 32'(master_accept), 32'd1);
      next_cycle();
      settle();
      chk("to_pulse_end", 32'(lock_timeout), 32'd0);
      chk("to_m1_gid", 32'(grant_id), 32'd1);
      next_cycle();
      settle();
      chk("to_block_gid", 32'(grant_id), 32'd0);
      chk("to_block_breq", 32'(bus_req), 32'd1);
`endif

      next_cycle();
      master_req = 2'b00;
      settle();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
